// File: rtl/vram_dump_streamer_if.sv
// Bus bundle for vram_dump_streamer: video RAM read port plus host SPI pins.
// master = the streamer, slave = the RAM/host side.
interface vram_dump_streamer_if #(
  parameter int VRAM_ADDR_W = 11
);
  logic [VRAM_ADDR_W-1:0] vram_read_address;
  logic                   vram_read_clock;
  logic [7:0]             vram_output;
  logic                   spi_cs;
  logic                   spi_clk_in;
  logic                   spi_out;

  modport master (
    output vram_read_address, vram_read_clock, spi_out,
    input  vram_output, spi_cs, spi_clk_in
  );

  modport slave (
    input  vram_read_address, vram_read_clock, spi_out,
    output vram_output, spi_cs, spi_clk_in
  );
endinterface

// File: rtl/vram_dump_streamer.sv
// vram_dump_streamer: prefetches video RAM bytes into a small FIFO and shifts
// them out MSB first to an SPI mode-0 host clocking asynchronously to clk.
// Optional feature macro: VRAM_DUMP_CHECKSUM_EN appends an XOR checksum byte.
//
// state  | meaning
// IDLE   | waiting for start
// ARMED  | prefetching, waiting for host chip-select to fall
// STREAM | shifting bytes out on host SPI clock falling edges
// FINISH | all bytes sent, waiting for chip-select to rise
module vram_dump_streamer #(
  parameter int VRAM_ADDR_W = 11,
  parameter int VRAM_BYTES  = 2048,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic underrun,
  vram_dump_streamer_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(VRAM_BYTES + 2);
`ifdef VRAM_DUMP_CHECKSUM_EN
  localparam int TOTAL_BYTES = VRAM_BYTES + 1;
`else
  localparam int TOTAL_BYTES = VRAM_BYTES;
`endif
  localparam logic [CNT_W-1:0]       DATA_CNT  = CNT_W'(VRAM_BYTES);
  localparam logic [CNT_W-1:0]       TOTAL_CNT = CNT_W'(TOTAL_BYTES);
  localparam logic [VRAM_ADDR_W-1:0] LAST_ADDR = VRAM_ADDR_W'(VRAM_BYTES - 1);
  localparam logic [PTR_W:0]         FIFO_CAP  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, STREAM, FINISH} state_t;

  state_t                 state_q, state_d;
  logic                   cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d, cs_prev_q, cs_prev_d;
  logic                   sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_prev_q, sck_prev_d;
  logic [VRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]       issued_q, issued_d;
  logic                   rd_pend_q, rd_pend_d;
  logic [PTR_W:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]       sent_q, sent_d;
  logic                   spi_out_q, spi_out_d;
  logic                   busy_q, busy_d;
  logic                   underrun_q, underrun_d;
`ifdef VRAM_DUMP_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0] fifo_cnt;
  logic           fifo_wr;
  logic           cs_fall, cs_rise, sck_fall;
  logic           load_byte, abort;
  logic [7:0]     byte_nxt;

  assign cs_fall  = cs_prev_q & ~cs_s2_q;
  assign cs_rise  = ~cs_prev_q & cs_s2_q;
  assign sck_fall = sck_prev_q & ~sck_s2_q;
  assign fifo_cnt = wr_ptr_q - rd_ptr_q;

  // Next-state logic: synchronisers, fetch engine, control FSM, shifter.
  always_comb begin
    state_d    = state_q;
    cs_s1_d    = bus.spi_cs;
    cs_s2_d    = cs_s1_q;
    cs_prev_d  = cs_s2_q;
    sck_s1_d   = bus.spi_clk_in;
    sck_s2_d   = sck_s1_q;
    sck_prev_d = sck_s2_q;
    addr_d     = addr_q;
    issued_d   = issued_q;
    rd_pend_d  = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    sent_d     = sent_q;
    busy_d     = busy_q;
    underrun_d = underrun_q;
`ifdef VRAM_DUMP_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    fifo_wr    = 1'b0;
    load_byte  = 1'b0;
    abort      = 1'b0;
    byte_nxt   = 8'h00;

    // Fetch engine: the read issued last cycle lands in the FIFO now; a new
    // read is issued only if it cannot overflow the FIFO.
    if (state_q == ARMED || state_q == STREAM) begin
      if (rd_pend_q) begin
        fifo_wr  = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if ((fifo_cnt + (PTR_W + 1)'(rd_pend_q)) < FIFO_CAP && issued_q != DATA_CNT) begin
        rd_pend_d = 1'b1;
        issued_d  = issued_q + 1'b1;
        if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ARMED;
          addr_d     = '0;
          issued_d   = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          sent_d     = '0;
          bit_cnt_d  = '0;
          underrun_d = 1'b0;
          busy_d     = 1'b1;
`ifdef VRAM_DUMP_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
        end
      end
      ARMED: begin
        if (cs_rise) abort = 1'b1;
        else if (cs_fall) begin
          state_d   = STREAM;
          load_byte = 1'b1;
        end
      end
      STREAM: begin
        if (cs_rise) abort = 1'b1;
        else if (sck_fall) begin
          if (bit_cnt_q != 3'd7) begin
            shreg_d   = {shreg_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (sent_q == TOTAL_CNT) begin
            state_d = FINISH;
          end else begin
            load_byte = 1'b1;
          end
        end
      end
      FINISH: begin
        if (cs_rise) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Byte boundary: data from the FIFO, 0x00 if it ran dry, checksum last.
    if (load_byte) begin
      if (sent_q < DATA_CNT) begin
        if (fifo_cnt != '0) begin
          byte_nxt = fifo_mem[rd_ptr_q[PTR_W-1:0]];
          rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
          underrun_d = 1'b1;
        end
`ifdef VRAM_DUMP_CHECKSUM_EN
        csum_d = csum_q ^ byte_nxt;
      end else begin
        byte_nxt = csum_q;
`endif
      end
      shreg_d   = byte_nxt;
      bit_cnt_d = '0;
      sent_d    = sent_q + 1'b1;
    end

    // Abort drops everything buffered and the read still in flight.
    if (abort) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      rd_pend_d = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end

    spi_out_d = (state_d == STREAM) ? shreg_d[7] : 1'b0;
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cs_s1_q    <= 1'b1;
      cs_s2_q    <= 1'b1;
      cs_prev_q  <= 1'b1;
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_prev_q <= 1'b0;
      addr_q     <= '0;
      issued_q   <= '0;
      rd_pend_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      shreg_q    <= 8'h00;
      bit_cnt_q  <= '0;
      sent_q     <= '0;
      spi_out_q  <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
`ifdef VRAM_DUMP_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      cs_s1_q    <= cs_s1_d;
      cs_s2_q    <= cs_s2_d;
      cs_prev_q  <= cs_prev_d;
      sck_s1_q   <= sck_s1_d;
      sck_s2_q   <= sck_s2_d;
      sck_prev_q <= sck_prev_d;
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      rd_pend_q  <= rd_pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      sent_q     <= sent_d;
      spi_out_q  <= spi_out_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
`ifdef VRAM_DUMP_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= bus.vram_output;
  end

  assign bus.vram_read_address = addr_q;
  assign bus.vram_read_clock   = clk;
  assign bus.spi_out           = spi_out_q;
  assign busy                  = busy_q;
  assign underrun              = underrun_q;
endmodule

// File: tb/tb_vram_dump_streamer.sv
// Bench for vram_dump_streamer: VRAM model, SPI mode-0 host, byte-stream
// reference computed from the memory image.
module tb_vram_dump_streamer;
  localparam int ADDR_W = 6;
  localparam int NBYTES = 40;
  localparam int DEPTH  = 4;
`ifdef VRAM_DUMP_CHECKSUM_EN
  localparam int NTOT = NBYTES + 1;
`else
  localparam int NTOT = NBYTES;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, underrun;
  logic [7:0] mem [NBYTES];
  logic [7:0] rx_q [$];
  int n_tests = 0;
  int n_fail = 0;
  int addr_viol = 0;

  vram_dump_streamer_if #(.VRAM_ADDR_W(ADDR_W)) bus ();

  vram_dump_streamer #(
    .VRAM_ADDR_W(ADDR_W), .VRAM_BYTES(NBYTES), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .underrun(underrun), .bus(bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read video RAM on the streamer's read clock.
  always @(posedge bus.vram_read_clock) begin
    if (int'(bus.vram_read_address) < NBYTES) bus.vram_output <= mem[bus.vram_read_address];
    else bus.vram_output <= 8'hEE;
  end

  always @(negedge clk) begin
    if (reset && int'(bus.vram_read_address) > NBYTES - 1) addr_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Host clocks nbits bits (mode 0: sample on rise, DUT shifts on fall).
  task automatic spi_bits(input int nbits, input int half);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      repeat (half) @(negedge clk);
      bus.spi_clk_in = 1'b1;
      b = {b[6:0], bus.spi_out};
      repeat (half) @(negedge clk);
      bus.spi_clk_in = 1'b0;
      if (k % 8 == 7) rx_q.push_back(b);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Complete transfer with FIFO primed; expected stream is the memory image.
  task automatic run_xfer(input string tag, input int half, input bit poke_start);
    logic [7:0] x;
    rx_q.delete();
    check({tag, "_busy_pre"}, 32'(busy), 32'd0);
    pulse_start();
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    repeat (10) @(negedge clk);
    bus.spi_cs = 1'b0;
    if (poke_start) begin
      fork
        begin
          repeat (150) @(negedge clk);
          start = 1'b1;
          @(negedge clk) start = 1'b0;
        end
      join_none
    end
    spi_bits(8 * (NTOT + 1), half);
    x = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(mem[i]));
      x ^= mem[i];
    end
`ifdef VRAM_DUMP_CHECKSUM_EN
    check({tag, "_csum"}, 32'(rx_q[NBYTES]), 32'(x));
`endif
    check({tag, "_finish_out"}, 32'(rx_q[NTOT]), 32'd0);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
    check({tag, "_busy_fin"}, 32'(busy), 32'd1);
    check({tag, "_addr_hold"}, 32'(bus.vram_read_address), 32'(NBYTES - 1));
    bus.spi_cs = 1'b1;
    repeat (5) @(negedge clk);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int j, subs, err;
    logic [7:0] x;
    bus.spi_cs = 1'b1;
    bus.spi_clk_in = 1'b0;
    bus.vram_output = 8'h00;
    for (int i = 0; i < NBYTES; i++) mem[i] = 8'(i);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", 32'(bus.spi_out), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_addr", 32'(bus.vram_read_address), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Address-pattern image at clk/8 SPI rate.
    run_xfer("ramp", 4, 1'b0);

    // Random images and host rates.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NBYTES; i++) mem[i] = 8'($urandom_range(0, 255));
      run_xfer($sformatf("rnd%0d", r), $urandom_range(4, 6), 1'b0);
    end

    // Host starts before the first fetch lands: stalled FIFO.
    for (int i = 0; i < NBYTES; i++) mem[i] = 8'($urandom_range(1, 255));
    rx_q.delete();
    @(negedge clk) begin start = 1'b1; bus.spi_cs = 1'b0; end
    @(negedge clk) start = 1'b0;
    spi_bits(8 * (NTOT + 1), 4);
    j = 0; subs = 0; err = 0; x = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (j < NBYTES && rx_q[i] == mem[j]) j++;
      else if (rx_q[i] == 8'h00) subs++;
      else err++;
      x ^= rx_q[i];
    end
    check("stall_order", 32'(err), 32'd0);
    check("stall_has_sub", 32'(subs > 0), 32'd1);
    check("stall_underrun", 32'(underrun), 32'd1);
`ifdef VRAM_DUMP_CHECKSUM_EN
    check("stall_csum", 32'(rx_q[NBYTES]), 32'(x));
`endif
    check("stall_finish_out", 32'(rx_q[NTOT]), 32'd0);
    check("stall_busy_fin", 32'(busy), 32'd1);
    bus.spi_cs = 1'b1;
    repeat (5) @(negedge clk);
    check("stall_idle", 32'(busy), 32'd0);

    // Abort after 13 bits, then a fresh dump restarts at address 0.
    rx_q.delete();
    pulse_start();
    check("abort_underrun_clr", 32'(underrun), 32'd0);
    repeat (10) @(negedge clk);
    bus.spi_cs = 1'b0;
    spi_bits(13, 4);
    check("abort_byte0", 32'(rx_q[0]), 32'(mem[0]));
    @(negedge clk) bus.spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out", 32'(bus.spi_out), 32'd0);
    run_xfer("post_abort", 5, 1'b0);

    // Asynchronous reset in the middle of a stalled stream.
    rx_q.delete();
    @(negedge clk) begin start = 1'b1; bus.spi_cs = 1'b0; end
    @(negedge clk) start = 1'b0;
    spi_bits(10, 4);
    check("pre_rst_underrun", 32'(underrun), 32'd1);
    bus.spi_clk_in = 1'b1;
    #3 reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out", 32'(bus.spi_out), 32'd0);
    check("mid_rst_underrun", 32'(underrun), 32'd0);
    check("mid_rst_addr", 32'(bus.vram_read_address), 32'd0);
    bus.spi_clk_in = 1'b0;
    bus.spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_out", 32'(bus.spi_out), 32'd0);

    // Start pulsed mid-transfer must not disturb the sequence.
    for (int i = 0; i < NBYTES; i++) mem[i] = 8'($urandom_range(0, 255));
    run_xfer("restart_ignored", 4, 1'b1);

    check("addr_range", 32'(addr_viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_dump_streamer.md
VRAM_DUMP_STREAMER -- requirements
Module: vram_dump_streamer

Interface
REQ-001 SHALL have parameter VRAM_ADDR_W, default 11, meaning the width of the video RAM read address.
REQ-002 SHALL have parameter VRAM_BYTES, default 2048, meaning the number of bytes dumped per transfer (1..2^VRAM_ADDR_W).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the prefetch FIFO entries (power of 2, min 2).
REQ-004 clk  input  1  system clock (internal oscillator domain); all state is sampled on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin a dump.
REQ-007 vram_read_address  output  VRAM_ADDR_W  video RAM read port address.
REQ-008 vram_read_clock  output  1  video RAM read clock; SHALL equal clk.
REQ-009 vram_output  input  8  video RAM read data, valid one clk after the address.
REQ-010 spi_cs  input  1  host chip select, active low, asynchronous to clk.
REQ-011 spi_clk_in  input  1  host SPI clock (mode 0), asynchronous to clk.
REQ-012 spi_out  output  1  serial data to host, MSB first.
REQ-013 busy  output  1  high from accepted start until return to IDLE.
REQ-014 underrun  output  1  sticky flag: a byte boundary was reached with the FIFO empty.

Function
REQ-015 SHALL synchronise spi_cs and spi_clk_in through two clk flops each and detect edges on the synchronised copies.
REQ-016 SHALL implement states IDLE, ARMED, STREAM, FINISH.
REQ-017 IDLE: start=1 -> ARMED; clears the address counter, byte counter, FIFO and underrun; busy rises the next cycle.
REQ-018 A start received while busy=1 SHALL be ignored.
REQ-019 ARMED/STREAM fetch engine: while issued-but-unread plus stored entries < FIFO_DEPTH and addresses remain, it SHALL issue the next address, writing vram_output into the FIFO one cycle later.
REQ-020 The address SHALL count 0..VRAM_BYTES-1 with no wrap; no read is issued after VRAM_BYTES-1.
REQ-021 ARMED: a synchronised spi_cs falling edge -> STREAM; the FIFO head is popped into the shift register and bit 7 is driven on spi_out.
REQ-022 STREAM: each synchronised spi_clk_in falling edge shifts the next bit out; after the 8th bit the next byte is loaded from the FIFO.
REQ-023 At a byte boundary with the FIFO empty and bytes still owed, the block SHALL load 0x00, set underrun, and keep counting the byte as sent.
REQ-024 After VRAM_BYTES bytes have been shifted (plus the checksum byte per REQ-031) -> FINISH; spi_out holds 0.
REQ-025 FINISH: a synchronised spi_cs rising edge -> IDLE.
REQ-026 spi_cs rising edge in ARMED or STREAM (abort) SHALL flush the FIFO, cancel the in-flight read and return to IDLE within 2 clk of the synchronised edge.
REQ-027 spi_out SHALL be 0 whenever the state is not STREAM.

Reset
REQ-028 reset low SHALL asynchronously force IDLE, vram_read_address=0, spi_out=0, busy=0, underrun=0, FIFO empty, synchroniser flops to idle levels (cs=1, clk=0).
REQ-029 reset mid-transfer SHALL discard all data; no partial byte is emitted after release.

Configuration
REQ-030 Macro VRAM_DUMP_CHECKSUM_EN SHALL select the checksum feature.
REQ-031 Defined: one extra byte, the XOR of all VRAM_BYTES bytes as shifted (0x00 substitutes included), SHALL follow the last data byte before FINISH.
REQ-032 Undefined: no checksum logic exists; FINISH follows the last data byte directly.

Verification
REQ-033 VRAM filled with addr[7:0], start, cs low, 2048x8 SPI clocks at clk/8 -> host receives 0x00,0x01..0xFF repeating, underrun=0, then FINISH.
REQ-034 VRAM_BYTES=4, data 0x12,0x34,0x56,0x78, VRAM_DUMP_CHECKSUM_EN defined -> bytes 12 34 56 78 08, then FINISH.
REQ-035 SPI clock faster than fetch rate (forced FIFO stall) -> 0x00 byte inserted, underrun=1, total byte count unchanged.
REQ-036 cs raised after 13 bits -> IDLE within 4 clk, busy=0; new start then yields byte 0 from address 0.
REQ-037 reset pulsed low during STREAM -> all outputs at reset values immediately; start pulse while busy -> no effect on address sequence.
